// File: rtl/lib_arb_pkg.sv
// Shared types and helpers for the round-robin arbiter library.
// The helper functions take a fixed maximum width so that one package serves
// every arbiter width. Callers zero-extend their vectors on the way in and
// truncate the result on the way out.
package lib_arb_pkg;

    localparam int ARB_MAXW = 64;
    localparam int ARB_IDXW = 6;

    typedef enum logic [0:0] {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_e;

    // Binary index of a one-hot vector; returns 0 for an all-zero vector.
    function automatic logic [ARB_IDXW-1:0] onehot2idx(input logic [ARB_MAXW-1:0] v);
        logic [ARB_IDXW-1:0] idx;
        idx = '0;
        for (int i = 0; i < ARB_MAXW; i++) begin
            if (v[i]) idx = idx | ARB_IDXW'(i);
        end
        return idx;
    endfunction

    // Rotate a w-bit one-hot vector by one position, wrapping within w bits.
    // up=1 moves toward the MSB (bit w-1 wraps to bit 0); up=0 moves toward the LSB.
    function automatic logic [ARB_MAXW-1:0] rot_onehot(input logic [ARB_MAXW-1:0] v,
                                                       input int w, input logic up);
        logic [ARB_MAXW-1:0] r;
        r = '0;
        for (int i = 0; i < ARB_MAXW; i++) begin
            if (i < w) begin
                if (up) r[(i + 1) % w]     = v[i];
                else    r[(i + w - 1) % w] = v[i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/lib_rr_pick.sv
// Combinational wrap-around priority pick.
// The function returns the first set request at or after the one-hot base
// position, searching in the configured direction. The search uses the
// doubled-vector trick. The subtraction borrows through the zeros from base
// up to the first set request, and that request is the only bit left standing
// after masking. The downward search reuses the same circuit on bit-reversed
// vectors.
module lib_rr_pick #(
    parameter int WIDTH   = 4,
    parameter int LSB_MSB = 1
) (
    input  logic [WIDTH-1:0] req,
    input  logic [WIDTH-1:0] base,
    output logic [WIDTH-1:0] pick
);

    logic [WIDTH-1:0]   w_req_o;
    logic [WIDTH-1:0]   w_base_o;
    logic [WIDTH-1:0]   w_pick_o;
    logic [2*WIDTH-1:0] w_dbl;
    logic [2*WIDTH-1:0] w_msk;

    generate
        if (LSB_MSB != 0) begin : g_up
            assign w_req_o  = req;
            assign w_base_o = base;
            assign pick     = w_pick_o;
        end else begin : g_down
            for (genvar i = 0; i < WIDTH; i++) begin : g_rev
                assign w_req_o[i]  = req[WIDTH-1-i];
                assign w_base_o[i] = base[WIDTH-1-i];
                assign pick[i]     = w_pick_o[WIDTH-1-i];
            end
        end
    endgenerate

    assign w_dbl    = {w_req_o, w_req_o};
    assign w_msk    = w_dbl & ~(w_dbl - {{WIDTH{1'b0}}, w_base_o});
    assign w_pick_o = w_msk[WIDTH-1:0] | w_msk[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/lib_rr_arbiter.sv
// Round-robin arbiter with a registered, rotating priority pointer.
// The grant is registered and held under backpressure. A new grant can be
// issued on the same edge that ends the previous one, so back-to-back grants
// have no bubble. WIDTH must not exceed lib_arb_pkg::ARB_MAXW.
module lib_rr_arbiter
    import lib_arb_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int LSB_MSB = 1,
    parameter int LOCK_EN = 0
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [WIDTH-1:0]         req,
    input  logic                     gnt_rdy,
    input  logic                     gnt_last,
    output logic                     gnt_vld,
    output logic [WIDTH-1:0]         gnt,
    output logic [$clog2(WIDTH)-1:0] gnt_idx,
    output logic [WIDTH-1:0]         ptr
);

    localparam logic [WIDTH-1:0] PTR_RST = (LSB_MSB != 0) ? WIDTH'(1)
                                                          : {1'b1, {(WIDTH-1){1'b0}}};

    arb_state_e       r_state;
    logic             r_vld;
    logic [WIDTH-1:0] r_gnt;
    logic [WIDTH-1:0] r_ptr;

    logic             w_any;
    logic             w_end;
    logic [WIDTH-1:0] w_ptr_nxt;
    logic [WIDTH-1:0] w_base;
    logic [WIDTH-1:0] w_pick;

    assign w_any     = |req;
    // The grant ends only on an accepted beat. In lock mode that beat must also be the last one.
    assign w_end     = (r_state == ARB_GRANT) && gnt_rdy && ((LOCK_EN == 0) || gnt_last);
    // After a grant, the priority base moves one position past the requester just served.
    assign w_ptr_nxt = WIDTH'(rot_onehot(ARB_MAXW'(r_gnt), WIDTH, LSB_MSB != 0));
    // In IDLE the pick uses the stored pointer. At grant end it uses the pointer about to be stored.
    assign w_base    = (r_state == ARB_IDLE) ? r_ptr : w_ptr_nxt;

    lib_rr_pick #(
        .WIDTH   (WIDTH),
        .LSB_MSB (LSB_MSB)
    ) u_pick (
        .req  (req),
        .base (w_base),
        .pick (w_pick)
    );

    // Grant FSM. The registers read req only in IDLE or at grant end, so the
    // grant is never revoked and an unknown req cannot leak into the outputs
    // during backpressure.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ARB_IDLE;
            r_vld   <= 1'b0;
            r_gnt   <= '0;
            r_ptr   <= PTR_RST;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_any) begin
                        r_gnt   <= w_pick;
                        r_vld   <= 1'b1;
                        r_state <= ARB_GRANT;
                    end
                end
                ARB_GRANT: begin
                    if (w_end) begin
                        r_ptr <= w_ptr_nxt;
                        if (w_any) begin
                            r_gnt <= w_pick;
                        end else begin
                            r_gnt   <= '0;
                            r_vld   <= 1'b0;
                            r_state <= ARB_IDLE;
                        end
                    end
                end
                default: r_state <= ARB_IDLE;
            endcase
        end
    end

    assign gnt_vld = r_vld;
    assign gnt     = r_gnt;
    assign gnt_idx = $clog2(WIDTH)'(onehot2idx(ARB_MAXW'(r_gnt)));
    assign ptr     = r_ptr;

endmodule

// File: tb/tb_lib_rr_arbiter.sv
// Directed bench for lib_rr_arbiter. Three instances cover the default,
// lock and downward-search configurations. Each step pushes the expected
// post-edge state to a scoreboard, and that entry is popped and compared
// one time unit after the edge.
module tb_lib_rr_arbiter;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    // sel 0: default (LSB_MSB=1, LOCK_EN=0); sel 1: lock; sel 2: downward search
    logic [3:0] req   [3];
    logic       rdy   [3];
    logic       last  [3];
    logic       vld   [3];
    logic [3:0] gnt   [3];
    logic [1:0] idx   [3];
    logic [3:0] ptr   [3];

    lib_rr_arbiter #(.WIDTH(4), .LSB_MSB(1), .LOCK_EN(0)) u_dut (
        .clk(clk), .rstn(rstn), .req(req[0]), .gnt_rdy(rdy[0]), .gnt_last(last[0]),
        .gnt_vld(vld[0]), .gnt(gnt[0]), .gnt_idx(idx[0]), .ptr(ptr[0]));

    lib_rr_arbiter #(.WIDTH(4), .LSB_MSB(1), .LOCK_EN(1)) u_lock (
        .clk(clk), .rstn(rstn), .req(req[1]), .gnt_rdy(rdy[1]), .gnt_last(last[1]),
        .gnt_vld(vld[1]), .gnt(gnt[1]), .gnt_idx(idx[1]), .ptr(ptr[1]));

    lib_rr_arbiter #(.WIDTH(4), .LSB_MSB(0), .LOCK_EN(0)) u_msb (
        .clk(clk), .rstn(rstn), .req(req[2]), .gnt_rdy(rdy[2]), .gnt_last(last[2]),
        .gnt_vld(vld[2]), .gnt(gnt[2]), .gnt_idx(idx[2]), .ptr(ptr[2]));

    typedef struct {
        int         sel;
        logic       vld;
        logic [3:0] gnt;
        logic [1:0] idx;
        logic [3:0] ptr;
        string      tag;
    } exp_t;

    exp_t q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic push(input int sel, input logic ev, input logic [3:0] eg,
                        input logic [1:0] ei, input logic [3:0] ep, input string tag);
        exp_t e;
        e.sel = sel; e.vld = ev; e.gnt = eg; e.idx = ei; e.ptr = ep; e.tag = tag;
        q.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        e = q.pop_front();
        n_cmp++;
        assert (vld[e.sel] === e.vld) else begin
            n_fail++;
            $error("FAIL %s gnt_vld observed=%b expected=%b", e.tag, vld[e.sel], e.vld);
        end
        n_cmp++;
        assert (gnt[e.sel] === e.gnt) else begin
            n_fail++;
            $error("FAIL %s gnt observed=%b expected=%b", e.tag, gnt[e.sel], e.gnt);
        end
        n_cmp++;
        assert (idx[e.sel] === e.idx) else begin
            n_fail++;
            $error("FAIL %s gnt_idx observed=%0d expected=%0d", e.tag, idx[e.sel], e.idx);
        end
        n_cmp++;
        assert (ptr[e.sel] === e.ptr) else begin
            n_fail++;
            $error("FAIL %s ptr observed=%b expected=%b", e.tag, ptr[e.sel], e.ptr);
        end
    endtask

    // Drive one cycle of stimulus, then check the state after the next edge.
    task automatic step(input int sel, input logic [3:0] rq, input logic rd, input logic lst,
                        input logic ev, input logic [3:0] eg, input logic [1:0] ei,
                        input logic [3:0] ep, input string tag);
        req[sel]  = rq;
        rdy[sel]  = rd;
        last[sel] = lst;
        push(sel, ev, eg, ei, ep, tag);
        @(posedge clk);
        #1;
        pop_check();
    endtask

    // Check the current state without a clock edge, for asynchronous reset.
    task automatic now(input int sel, input logic ev, input logic [3:0] eg,
                       input logic [1:0] ei, input logic [3:0] ep, input string tag);
        push(sel, ev, eg, ei, ep, tag);
        pop_check();
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            req[i] = 4'b0000; rdy[i] = 1'b0; last[i] = 1'b0;
        end
        rstn   = 1'b0;
        req[0] = 4'b1111;

        // Reset holds the outputs cleared across an edge, even with all requests set.
        @(posedge clk); #1;
        now(0, 1'b0, 4'b0000, 2'd0, 4'b0001, "rst_dflt");
        now(1, 1'b0, 4'b0000, 2'd0, 4'b0001, "rst_lock");
        now(2, 1'b0, 4'b0000, 2'd0, 4'b1000, "rst_msb");
        @(posedge clk); #1;
        rstn = 1'b1;

        // The first grant appears one edge after release. It is held while gnt_rdy=0.
        step(0, 4'b1111, 1'b0, 1'b0, 1'b1, 4'b0001, 2'd0, 4'b0001, "first_gnt");
        // Rotation with all requests set and no bubbles.
        step(0, 4'b1111, 1'b1, 1'b0, 1'b1, 4'b0010, 2'd1, 4'b0010, "rr1");
        step(0, 4'b1111, 1'b1, 1'b0, 1'b1, 4'b0100, 2'd2, 4'b0100, "rr2");
        step(0, 4'b1111, 1'b1, 1'b0, 1'b1, 4'b1000, 2'd3, 4'b1000, "rr3");
        step(0, 4'b1111, 1'b1, 1'b0, 1'b1, 4'b0001, 2'd0, 4'b0001, "rr_wrap");
        step(0, 4'b1111, 1'b1, 1'b0, 1'b1, 4'b0010, 2'd1, 4'b0010, "rr5");

        // Backpressure: grant and ptr stay frozen while req toggles.
        step(0, 4'b0000, 1'b0, 1'b0, 1'b1, 4'b0010, 2'd1, 4'b0010, "bp1");
        step(0, 4'b1000, 1'b0, 1'b0, 1'b1, 4'b0010, 2'd1, 4'b0010, "bp2");
        step(0, 4'b0101, 1'b0, 1'b0, 1'b1, 4'b0010, 2'd1, 4'b0010, "bp3");
        // The grant is accepted with no request pending, so the FSM returns to IDLE.
        step(0, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000, 2'd0, 4'b0100, "bp_end");

        // Wrap: ptr reaches 1000 and the pick wraps around to requester 1.
        step(0, 4'b0100, 1'b1, 1'b0, 1'b1, 4'b0100, 2'd2, 4'b0100, "wrap_setup");
        step(0, 4'b0010, 1'b1, 1'b0, 1'b1, 4'b0010, 2'd1, 4'b1000, "wrap_pick");
        step(0, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000, 2'd0, 4'b0100, "wrap_idle");
        step(0, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000, 2'd0, 4'b0100, "idle_ptr_hold");

        // Lock mode: requester 0 keeps the grant until the beat with gnt_last=1.
        step(1, 4'b0101, 1'b1, 1'b0, 1'b1, 4'b0001, 2'd0, 4'b0001, "lock_gnt");
        step(1, 4'b0101, 1'b1, 1'b0, 1'b1, 4'b0001, 2'd0, 4'b0001, "lock_beat1");
        step(1, 4'b0101, 1'b1, 1'b0, 1'b1, 4'b0001, 2'd0, 4'b0001, "lock_beat2");
        step(1, 4'b0101, 1'b1, 1'b1, 1'b1, 4'b0100, 2'd2, 4'b0010, "lock_last");
        step(1, 4'b0000, 1'b1, 1'b1, 1'b0, 4'b0000, 2'd0, 4'b1000, "lock_idle");

        // Downward search direction.
        step(2, 4'b1111, 1'b1, 1'b0, 1'b1, 4'b1000, 2'd3, 4'b1000, "msb1");
        step(2, 4'b1111, 1'b1, 1'b0, 1'b1, 4'b0100, 2'd2, 4'b0100, "msb2");
        step(2, 4'b1111, 1'b1, 1'b0, 1'b1, 4'b0010, 2'd1, 4'b0010, "msb3");
        step(2, 4'b1111, 1'b1, 1'b0, 1'b1, 4'b0001, 2'd0, 4'b0001, "msb4");
        step(2, 4'b1111, 1'b1, 1'b0, 1'b1, 4'b1000, 2'd3, 4'b1000, "msb_wrap");
        step(2, 4'b1111, 1'b1, 1'b0, 1'b1, 4'b0100, 2'd2, 4'b0100, "msb_mid");

        // Asynchronous reset mid-grant takes effect before any clock edge.
        rstn = 1'b0;
        #1;
        now(2, 1'b0, 4'b0000, 2'd0, 4'b1000, "msb_async_rst");
        now(0, 1'b0, 4'b0000, 2'd0, 4'b0001, "dflt_async_rst");
        @(posedge clk); #1;
        rstn = 1'b1;
        // The first cycle after release behaves as IDLE.
        step(2, 4'b0010, 1'b1, 1'b0, 1'b1, 4'b0010, 2'd1, 4'b1000, "msb_after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/lib_rr_arbiter.md
Name: lib_rr_arbiter

Overview:
Parametrised round-robin arbiter with a registered, rotating priority pointer and a valid/ready grant handshake.
- Each cycle it picks the first set request at or after the pointer, with wrap-around, in a configurable search direction.
- The grant is registered and held under backpressure. An optional lock mode holds the grant across multi-beat transfers.
- Sits in front of shared resources (shared memory port, shared encoder/decoder engine) in the datapath library.

Parameters:
- WIDTH, 4, number of requesters (≥2).
- LSB_MSB, 1, search direction: 1 = index 0 upward, 0 = index WIDTH-1 downward.
- LOCK_EN, 0, 1 = grant held until an accepted beat with gnt_last=1; 0 = every accepted beat ends the grant.

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- req  in  WIDTH  request vector, one bit per requester.
- gnt_rdy  in  1  consumer accepts the current grant beat.
- gnt_last  in  1  last beat of locked transfer (ignored when LOCK_EN=0).
- gnt_vld  out  1  gnt/gnt_idx valid.
- gnt  out  WIDTH  one-hot grant.
- gnt_idx  out  $clog2(WIDTH)  binary index of gnt.
- ptr  out  WIDTH  one-hot current priority base (debug/visibility).

Behaviour:
- Clock/reset: single clock domain; reset is asynchronous, active-low. Asserting rstn clears outputs immediately, without waiting for a clock edge.
- Reset values:
  - gnt_vld=0, gnt=0, gnt_idx=0, state=IDLE.
  - ptr = bit0 (LSB_MSB=1) or bit WIDTH-1 (LSB_MSB=0).
- Pick function (combinational):
  - Take the first set bit of req, scanning from base in the search direction and wrapping past the end.
  - base itself has highest priority.
  - req=0 gives no pick.
- FSM states IDLE and GRANT:
  - IDLE: if |req, register gnt=pick(req, ptr), gnt_vld=1, go to GRANT. Latency: req at edge n gives gnt_vld at n+1. If req=0, stay in IDLE.
  - GRANT, gnt_rdy=0: gnt, gnt_idx, gnt_vld and ptr held stable; changes on req ignored.
  - GRANT, gnt_rdy=1 and (LOCK_EN=0 or gnt_last=1): grant ends.
    - ptr_nxt = gnt rotated one position in the search direction, wrapping (e.g. WIDTH=4, LSB_MSB=1: 1000→0001).
    - If |req this cycle: gnt=pick(req, ptr_nxt), gnt_vld stays 1 (back-to-back, no bubble).
    - Otherwise: gnt_vld=0, go to IDLE.
  - GRANT, gnt_rdy=1, LOCK_EN=1, gnt_last=0: beat accepted; grant and ptr unchanged.
- Grant is never revoked. A requester dropping req while granted does not change gnt until the grant ends.
- The just-served requester gets lowest priority on the next pick, because ptr has moved past it.
- gnt_idx is always consistent with gnt; both are 0 when gnt_vld=0.
- ptr updates only at grant end; it never moves in IDLE.
- Reset mid-transfer: gnt_vld drops asynchronously and ptr returns to its reset value. The first cycle after reset release behaves as IDLE.
- X-safety: no output depends on req while gnt_vld=1 and gnt_rdy=0.

Decomposition:
- Package lib_arb_pkg:
  - state enum {IDLE, GRANT};
  - function onehot2idx;
  - function rotate-one-hot (direction argument).
- Sub-module lib_rr_pick:
  - combinational wrap-around priority pick;
  - inputs req, base (one-hot), direction parameter; output one-hot pick;
  - implemented as a double-width vector minus base, masked.
- The top level holds the FSM, ptr register and output registers.

Test Plan:
1. Reset with req=1111 -> gnt_vld=0, gnt=0000, ptr=0001 during reset. First grant 0001 at edge 1 after release.
2. WIDTH=4, LSB_MSB=1, LOCK_EN=0, req=1111 held, gnt_rdy=1 -> gnt sequence 0001,0010,0100,1000,0001 on consecutive cycles, gnt_idx 0,1,2,3,0, no bubble.
3. Backpressure: gnt=0010, gnt_rdy=0 for 3 cycles while req toggles -> gnt/gnt_idx/ptr stable. After gnt_rdy=1, ptr=0100.
4. Wrap: ptr=1000 with req=0010, LSB_MSB=1 -> gnt=0010. req=0000 after accept -> gnt_vld=0, state IDLE, ptr=0100.
5. LOCK_EN=1, req=0101, gnt_rdy=1, gnt_last=1 on 3rd beat -> gnt=0001 for 3 beats, then 0100.
6. LSB_MSB=0, req=1111, gnt_rdy=1 -> 1000,0100,0010,0001. Assert rstn=0 mid-grant -> gnt_vld=0 immediately, ptr=1000.
